fb_render_scheduler: RTL

// - Sequences double-buffered Mandelbrot frame rendering: starts the pixel engines and merges their

---
 rtl/mandel_fb_pkg.sv | 19 +
 rtl/fb_rr_arbiter.sv | 41 ++++
 rtl/fb_render_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mandel_fb_pkg.sv
// Shared definitions for the double-buffered Mandelbrot framebuffer scheduler.
// Contents: scheduler FSM state encoding, default framebuffer address/data
// widths, and the widths of the optional statistics counters.
package mandel_fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RENDER  = 3'd2,
        ST_WAIT_VB = 3'd3,
        ST_SWAP    = 3'd4
    } fb_state_t;

    localparam int FB_ADDR_W    = 19;
    localparam int FB_DATA_W    = 8;
    localparam int FRAME_CNT_W  = 16;
    localparam int RENDER_CYC_W = 32;

endpackage

// File: rtl/fb_rr_arbiter.sv
// N-way round-robin arbiter (purely combinational).
// Ports:
//   i_en   - arbitration enable; no grant while low
//   i_req  - per-requester request bits
//   i_ptr  - highest-priority requester index
//   o_gnt  - one-hot grant
//   o_idx  - index of the granted requester
//   o_vld  - a grant was issued this cycle
module fb_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_en,
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    logic [IDX_W-1:0] w_cand;

    // Scan candidates from the farthest to the nearest position after the
    // pointer; the last hit wins, so the nearest requester ends up granted.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N);
            if (i_en && i_req[w_cand]) begin
                o_gnt         = '0;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_vld         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_render_scheduler.sv
// Double-buffered frame render scheduler: starts the pixel engines, merges
// their writes round-robin onto the single framebuffer write port, and swaps
// front/back buffers in vertical blank once the back buffer is complete.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   render_req            - pulse: render a new frame
//   vblank_pulse          - pulse: start of vertical blank
//   eng_start             - pulse to all engines: begin frame
//   eng_req/addr/data     - per-engine write requests (packed per engine)
//   eng_gnt               - one-hot combinational grant
//   eng_done              - pulse: engine finished its share
//   fb_we/waddr/wdata     - registered back-buffer write port
//   wr_buf_sel/rd_buf_sel - back/front buffer selects
//   busy                  - scheduler not idle
//   frame_cnt, render_cycles - statistics, only with FB_SCHED_STATS_EN defined
module fb_render_scheduler
    import mandel_fb_pkg::*;
#(
    parameter int N_ENG  = 4,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    render_req,
    input  logic                    vblank_pulse,
    output logic                    eng_start,
    input  logic [N_ENG-1:0]        eng_req,
    input  logic [N_ENG*ADDR_W-1:0] eng_addr,
    input  logic [N_ENG*DATA_W-1:0] eng_data,
    output logic [N_ENG-1:0]        eng_gnt,
    input  logic [N_ENG-1:0]        eng_done,
    output logic                    fb_we,
    output logic [ADDR_W-1:0]       fb_waddr,
    output logic [DATA_W-1:0]       fb_wdata,
    output logic                    wr_buf_sel,
    output logic                    rd_buf_sel,
`ifdef FB_SCHED_STATS_EN
    output logic [FRAME_CNT_W-1:0]  frame_cnt,
    output logic [RENDER_CYC_W-1:0] render_cycles,
`endif
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_ENG);

    fb_state_t          r_state;
    logic               r_eng_start;
    logic               r_fb_we;
    logic [ADDR_W-1:0]  r_fb_waddr;
    logic [DATA_W-1:0]  r_fb_wdata;
    logic               r_rd_buf_sel;
    logic [IDX_W-1:0]   r_ptr;
    logic [N_ENG-1:0]   r_done_mask;
    logic               r_pending;

    logic [N_ENG-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_vld;
    logic               w_frame_done;

    fb_rr_arbiter #(
        .N     (N_ENG),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_en  (r_state == ST_RENDER),
        .i_req (eng_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    // Frame is complete only once every engine reported done and the last
    // granted write has drained out of the write register.
    assign w_frame_done = (&r_done_mask) && (eng_req == '0) && !r_fb_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_eng_start  <= 1'b0;
            r_fb_we      <= 1'b0;
            r_fb_waddr   <= '0;
            r_fb_wdata   <= '0;
            r_rd_buf_sel <= 1'b0;
            r_ptr        <= '0;
            r_done_mask  <= '0;
            r_pending    <= 1'b0;
        end else begin
            // write register stage
            r_fb_we     <= w_vld;
            r_eng_start <= 1'b0;
            if (w_vld) begin
                r_fb_waddr <= eng_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                r_fb_wdata <= eng_data[int'(w_idx)*DATA_W +: DATA_W];
                r_ptr      <= (w_idx == IDX_W'(N_ENG - 1)) ? '0 : w_idx + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (render_req) begin
                        r_state     <= ST_START;
                        r_eng_start <= 1'b1;
                    end
                end
                ST_START: begin
                    r_done_mask <= '0;
                    r_state     <= ST_RENDER;
                    if (render_req) r_pending <= 1'b1;
                end
                ST_RENDER: begin
                    if (render_req) r_pending <= 1'b1;
                    r_done_mask <= r_done_mask | eng_done;
                    if (w_frame_done) r_state <= ST_WAIT_VB;
                end
                ST_WAIT_VB: begin
                    if (render_req) r_pending <= 1'b1;
                    // Toggle on the entry edge so the display flips the cycle
                    // right after the vblank pulse.
                    if (vblank_pulse) begin
                        r_state      <= ST_SWAP;
                        r_rd_buf_sel <= ~r_rd_buf_sel;
                    end
                end
                ST_SWAP: begin
                    r_pending <= 1'b0;
                    if (r_pending || render_req) begin
                        r_state     <= ST_START;
                        r_eng_start <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign eng_gnt    = w_gnt;
    assign eng_start  = r_eng_start;
    assign fb_we      = r_fb_we;
    assign fb_waddr   = r_fb_waddr;
    assign fb_wdata   = r_fb_wdata;
    assign rd_buf_sel = r_rd_buf_sel;
    assign wr_buf_sel = ~r_rd_buf_sel;
    assign busy       = (r_state != ST_IDLE);

`ifdef FB_SCHED_STATS_EN
    logic [FRAME_CNT_W-1:0]  r_frame_cnt;
    logic [RENDER_CYC_W-1:0] r_render_cycles;
    logic [RENDER_CYC_W-1:0] r_cyc_acc;

    function automatic logic [RENDER_CYC_W-1:0] sat_inc(input logic [RENDER_CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // r_cyc_acc counts START plus RENDER cycles of the frame in flight;
    // it is published when the frame enters WAIT_VB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt     <= '0;
            r_render_cycles <= '0;
            r_cyc_acc       <= '0;
        end else begin
            if (r_state == ST_START) r_cyc_acc <= RENDER_CYC_W'(1);
            if (r_state == ST_RENDER) begin
                r_cyc_acc <= sat_inc(r_cyc_acc);
                if (w_frame_done) r_render_cycles <= sat_inc(r_cyc_acc);
            end
            if (r_state == ST_WAIT_VB && vblank_pulse)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt     = r_frame_cnt;
    assign render_cycles = r_render_cycles;
`endif

endmodule
